param_root_iter: RTL and testbench

- Inverse of the team's pipelined power block, which produces x^(2^LATENCY).
- Takes a 64-bit value y and returns floor(y^(1/2^LEVELS)) by nesting LEVELS integer square roots: floor(sqrt(floor(sqrt(...)))).
- Multi-cycle, one result bit per clock, using the digit-by-digit (restoring) square-root method. Valid/ready handshake on both sides.
- Sits downstream of the power block in the loopback check path: x -> x^8 -> root -> x.

---
 rtl/param_root_iter.sv | 113 +++++++++++
 tb/tb_param_root_iter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_root_iter.sv
// Iterative integer root: floor(y^(1/2^LEVELS)) built from LEVELS nested square roots.
// Each root is computed with the restoring digit-by-digit method, one bit per clock.
module param_root_iter #(
    parameter int unsigned LEVELS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [63:0] i_data,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_data,
    output logic        o_exact
);

    if (LEVELS < 1 || LEVELS > 5) begin : gen_levels_check
        $error("param_root_iter: LEVELS must be in 1..5");
    end

    localparam logic [2:0] LastLevel = 3'(LEVELS - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [63:0] radicand;
    logic [33:0] rem;
    logic [31:0] root;
    logic [4:0]  bit_idx;
    logic [2:0]  level;
    logic        exact_acc;

    logic [1:0]  pair;
    logic [33:0] rem_sh;
    logic [33:0] trial;
    logic        take;
    logic [33:0] rem_nxt;
    logic [31:0] root_nxt;
    logic        exact_nxt;
    logic [4:0]  next_bits;

    always_comb begin
        pair      = radicand[{bit_idx, 1'b0} +: 2];
        rem_sh    = 34'({rem, pair});
        trial     = {root, 2'b01};
        take      = (rem_sh >= trial);
        rem_nxt   = take ? (rem_sh - trial) : rem_sh;
        root_nxt  = {root[30:0], take};
        exact_nxt = exact_acc & (rem_nxt == 34'd0);
        // Next level has half the width: (32 >> (level+1)) - 1 bit positions.
        next_bits = 5'd15 >> level;
    end

    assign i_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            radicand  <= '0;
            rem       <= '0;
            root      <= '0;
            bit_idx   <= '0;
            level     <= '0;
            exact_acc <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_exact   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        radicand  <= i_data;
                        rem       <= '0;
                        root      <= '0;
                        bit_idx   <= 5'd31;
                        level     <= '0;
                        exact_acc <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    if (bit_idx == 5'd0) begin
                        exact_acc <= exact_nxt;
                        if (level != LastLevel) begin
                            radicand <= {32'd0, root_nxt};
                            level    <= level + 3'd1;
                            rem      <= '0;
                            root     <= '0;
                            bit_idx  <= next_bits;
                        end else begin
                            o_data  <= root_nxt;
                            o_exact <= exact_nxt;
                            o_valid <= 1'b1;
                            state   <= DONE;
                        end
                    end else begin
                        bit_idx <= bit_idx - 5'd1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_root_iter.sv
// Scoreboard bench for param_root_iter: LEVELS=3 and LEVELS=1 instances.
// Stimulus pushes expected {exact, data}; negedge monitors pop on each output transfer.
module tb_param_root_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_ready = 1'b1;

    logic        i_valid3 = 1'b0;
    logic [63:0] i_data3 = '0;
    logic        i_ready3, o_valid3, o_exact3;
    logic [31:0] o_data3;

    logic        i_valid1 = 1'b0;
    logic [63:0] i_data1 = '0;
    logic        i_ready1, o_valid1, o_exact1;
    logic [31:0] o_data1;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    logic [32:0] q3[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    param_root_iter #(.LEVELS(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid3),
        .i_ready (i_ready3),
        .i_data  (i_data3),
        .o_valid (o_valid3),
        .o_ready (o_ready),
        .o_data  (o_data3),
        .o_exact (o_exact3)
    );

    param_root_iter #(.LEVELS(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid1),
        .i_ready (i_ready1),
        .i_data  (i_data1),
        .o_valid (o_valid1),
        .o_ready (o_ready),
        .o_data  (o_data1),
        .o_exact (o_exact1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Output transfer happens on the next posedge when both are high here.
    always @(negedge clk) begin
        if (rst_n && o_valid3 && o_ready) begin
            if (q3.size() == 0) begin
                check("dut3 unexpected output", 64'(o_data3), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = q3.pop_front();
                check("dut3 o_data", 64'(o_data3), 64'(e[31:0]));
                check("dut3 o_exact", 64'(o_exact3), 64'(e[32]));
            end
        end
        if (rst_n && o_valid1 && o_ready) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected output", 64'(o_data1), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = q1.pop_front();
                check("dut1 o_data", 64'(o_data1), 64'(e[31:0]));
                check("dut1 o_exact", 64'(o_exact1), 64'(e[32]));
            end
        end
    end

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic send3(input logic [63:0] y, input logic push, input logic [31:0] ed,
                         input logic ee, output int acc);
        int  t;
        logic ok;
        t  = 0;
        ok = 1'b0;
        i_valid3 = 1'b1;
        i_data3  = y;
        if (push) q3.push_back({ee, ed});
        while (!ok && t < 400) begin
            ok = i_ready3;
            @(posedge clk);
            #1;
            t++;
        end
        i_valid3 = 1'b0;
        if (!ok) check("dut3 accept timeout", 64'(ok), 64'd1);
        acc = cyc;
    endtask

    task automatic wait_out3(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!o_valid3 && lat < 400) begin
            if (i_ready3) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (i_ready3) busy_ok = 1'b0;
    endtask

    task automatic run3(input logic [63:0] y, input logic [31:0] ed, input logic ee);
        int   acc, lat;
        logic busy;
        send3(y, 1'b1, ed, ee, acc);
        wait_out3(lat, busy);
        check("dut3 latency", 64'(lat), 64'd56);
        check("dut3 i_ready low while busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          acc, prev, lat, t;
        logic        busy, ok;
        logic [31:0] d;
        logic        e;
        logic [63:0] p;

        #1;
        check("reset i_ready", 64'(i_ready3), 64'd1);
        check("reset o_valid", 64'(o_valid3), 64'd0);
        check("reset o_data", 64'(o_data3), 64'd0);
        check("reset o_exact", 64'(o_exact3), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run3(64'd0, 32'd0, 1'b1);
        run3(64'd9227446944279201, 32'd99, 1'b1);
        run3(64'd10000000000000000, 32'd100, 1'b1);
        run3(64'd9999999999999999, 32'd99, 1'b0);
        run3(64'hFFFF_FFFF_FFFF_FFFF, 32'd255, 1'b0);

        // LEVELS=1 instance, all-ones input
        check("dut1 idle ready", 64'(i_ready1), 64'd1);
        q1.push_back({1'b0, 32'hFFFF_FFFF});
        i_valid1 = 1'b1;
        i_data1  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        i_valid1 = 1'b0;
        lat = 0;
        while (!o_valid1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("dut1 latency", 64'(lat), 64'd32);
        @(posedge clk);
        #1;

        // Backpressure
        o_ready = 1'b0;
        send3(64'd10000000000000000, 1'b1, 32'd100, 1'b1, acc);
        wait_out3(lat, busy);
        check("bp latency", 64'(lat), 64'd56);
        d  = o_data3;
        e  = o_exact3;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!o_valid3 || o_data3 !== d || o_exact3 !== e || i_ready3) ok = 1'b0;
        end
        check("bp hold stable", 64'(ok), 64'd1);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp o_valid after transfer", 64'(o_valid3), 64'd0);
        check("bp i_ready after transfer", 64'(i_ready3), 64'd1);

        // i_valid with changing data during CALC must be ignored
        send3(64'd9227446944279201, 1'b1, 32'd99, 1'b1, acc);
        for (int i = 0; i < 30; i++) begin
            i_valid3 = 1'b1;
            i_data3  = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        i_valid3 = 1'b0;
        wait_out3(lat, busy);
        check("ignore-input latency", 64'(lat + 30), 64'd56);
        @(posedge clk);
        #1;

        // Reset mid-CALC aborts the operation
        send3(64'd9999999999999999, 1'b0, 32'd0, 1'b0, acc);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort o_valid", 64'(o_valid3), 64'd0);
        check("abort i_ready", 64'(i_ready3), 64'd1);
        check("abort o_data", 64'(o_data3), 64'd0);
        check("abort o_exact", 64'(o_exact3), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run3(64'd16, 32'd1, 1'b0);

        // Loopback: x -> x^8 (power block model) -> root, back-to-back accepts
        ok   = 1'b1;
        prev = 0;
        for (int x = 0; x < 100; x++) begin
            p = 64'(x);
            p = p * p;
            p = p * p;
            p = p * p;
            send3(p, 1'b1, 32'(x), 1'b1, acc);
            if (x > 0 && acc - prev != 58) ok = 1'b0;
            prev = acc;
        end
        check("loopback accept spacing", 64'(ok), 64'd1);

        t = 0;
        while ((q3.size() != 0 || q1.size() != 0) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("dut3 queue drained", 64'(q3.size()), 64'd0);
        check("dut1 queue drained", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
